// File: rtl/fft_input_reorder.sv
// fft_input_reorder: stores natural-order complex frames in a ping-pong buffer and replays them in bit-reversed order.
// Optional build macro FFT_IN_SIGNMAG_CONV_EN converts two's-complement inputs to sign-magnitude before storage.
module fft_input_reorder #(
  parameter int N    = 32,
  parameter int LOGN = 5,
  parameter int W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_re,
  input  logic [W-1:0]    in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_re,
  output logic [W-1:0]    out_im,
  output logic [LOGN-1:0] out_idx,
  output logic            out_last,
  output logic            frame_drop
);

  // Stall counter saturates at 2N+1, which needs LOGN+2 bits.
  localparam int              SCW       = LOGN + 2;
  localparam logic [LOGN-1:0] LAST      = LOGN'(N - 1);
  localparam logic [SCW-1:0]  DROP_AT   = SCW'(2 * N);
  localparam logic [SCW-1:0]  STALL_SAT = SCW'(2 * N + 1);

  logic [1:0]      full;
  logic            wb, rb;
  logic [LOGN-1:0] wcnt, rcnt;
  logic [2*W-1:0]  mem [0:2*N-1];

  logic            wr_en, rd_en, advance, stalled;
  logic [W-1:0]    wr_re, wr_im;
  logic            p_valid;
  logic [LOGN-1:0] p_idx;
  logic [2*W-1:0]  p_data;
  logic [SCW-1:0]  stall_cnt;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

`ifdef FFT_IN_SIGNMAG_CONV_EN
  // Most negative input has no sign-magnitude equivalent and saturates to all ones.
  function automatic logic [W-1:0] to_signmag(input logic [W-1:0] v);
    logic [W-1:0] mag;
    if (!v[W-1]) return v;
    mag = -v;
    if (mag[W-1]) return '1;
    return {1'b1, mag[W-2:0]};
  endfunction

  assign wr_re = to_signmag(in_re);
  assign wr_im = to_signmag(in_im);
`else
  assign wr_re = in_re;
  assign wr_im = in_im;
`endif

  assign in_ready = !rst && !full[wb];
  assign wr_en    = in_valid && in_ready;
  assign stalled  = in_valid && !in_ready;
  // The read pipeline (p stage plus output register) moves only when the output slot frees up.
  assign advance  = !out_valid || out_ready;
  assign rd_en    = full[rb] && advance;

  // NOTE: sample storage has no reset; stale contents are never visible because full[] gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb, wcnt}] <= {wr_re, wr_im};
  end

  always_ff @(posedge clk) begin
    if (rd_en) p_data <= mem[{rb, bitrev(rcnt)}];
  end

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      p_valid    <= 1'b0;
      p_idx      <= '0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      stall_cnt  <= '0;
      frame_drop <= 1'b0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end
      end

      if (rd_en) begin
        rcnt  <= rcnt + 1'b1;
        p_idx <= rcnt;
        if (rcnt == LAST) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
        end
      end

      if (advance) begin
        p_valid   <= rd_en;
        out_valid <= p_valid;
        out_last  <= p_valid && (p_idx == LAST);
        if (p_valid) begin
          out_re  <= p_data[2*W-1:W];
          out_im  <= p_data[W-1:0];
          out_idx <= p_idx;
        end
      end

      // Diagnostic only: one pulse on the (2N+1)th consecutive stalled cycle.
      if (stalled) begin
        if (stall_cnt != STALL_SAT) stall_cnt <= stall_cnt + 1'b1;
        frame_drop <= (stall_cnt == DROP_AT);
      end else begin
        stall_cnt  <= '0;
        frame_drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder: randomized streams scored against a frame-level bit-reversal model.
module tb_fft_input_reorder;
  localparam int N    = 32;
  localparam int LOGN = 5;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [W-1:0]    in_re, in_im;
  logic            out_valid, out_ready;
  logic [W-1:0]    out_re, out_im;
  logic [LOGN-1:0] out_idx;
  logic            out_last, frame_drop;

  always #5 clk = ~clk;

  fft_input_reorder #(.N(N), .LOGN(LOGN), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .frame_drop(frame_drop)
  );

  typedef struct { logic [W-1:0] re; logic [W-1:0] im; } samp_t;
  typedef struct { logic [W-1:0] re; logic [W-1:0] im; int idx; } exp_t;

  samp_t        src[$];
  samp_t        frame[$];
  exp_t         exp_q[$];
  logic [W-1:0] got_re[$];

  int checks = 0, failures = 0;
  int cyc = 0, valid_pct = 100, ready_pct = 100;
  int stall_run, stall_total, drop_seen, outs;
  int first_valid_cyc, last_accept_cyc, first_out_cyc, last_out_cyc;
  logic            drop_exp, prev_hold, h_last;
  logic [W-1:0]    h_re, h_im;
  logic [LOGN-1:0] h_idx;

  // Input format conversion written from the numeric definition.
  function automatic logic [W-1:0] model_conv(input logic [W-1:0] x);
`ifdef FFT_IN_SIGNMAG_CONV_EN
    int v, m;
    v = int'($signed(x));
    if (v >= 0) return x;
    m = -v;
    if (m > (1 << (W - 1)) - 1) return '1;
    return W'((1 << (W - 1)) + m);
`else
    return x;
`endif
  endfunction

  function automatic int bitrev_int(input int k);
    int j = 0;
    for (int b = 0; b < LOGN; b++)
      if ((k >> b) & 1) j += 1 << (LOGN - 1 - b);
    return j;
  endfunction

  task automatic model_reset();
    src.delete();
    frame.delete();
    exp_q.delete();
    stall_run = 0;
    drop_exp  = 1'b0;
    prev_hold = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample 1ns later, score the handshakes of the next rising edge.
  task automatic tick();
    samp_t s;
    exp_t  e;
    @(negedge clk);
    cyc++;
    in_valid = (src.size() > 0) && ($urandom_range(99) < valid_pct);
    if (in_valid) begin
      in_re = src[0].re;
      in_im = src[0].im;
    end else begin
      in_re = W'($urandom);
      in_im = W'($urandom);
    end
    out_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (rst) begin
      model_reset();
      return;
    end

    if (prev_hold) begin
      checks++;
      if (out_valid !== 1'b1 || out_re !== h_re || out_im !== h_im || out_idx !== h_idx || out_last !== h_last) begin
        failures++;
        $display("FAIL hold cyc=%0d got v=%b re=%h im=%h idx=%0d last=%b want v=1 re=%h im=%h idx=%0d last=%b",
                 cyc, out_valid, out_re, out_im, out_idx, out_last, h_re, h_im, h_idx, h_last);
      end
    end

    checks++;
    if (frame_drop !== drop_exp) begin
      failures++;
      $display("FAIL frame_drop cyc=%0d got=%b want=%b", cyc, frame_drop, drop_exp);
    end
    if (frame_drop === 1'b1) drop_seen++;
    if (in_valid && !in_ready) begin
      stall_run++;
      stall_total++;
    end else begin
      stall_run = 0;
    end
    drop_exp = (stall_run == 2 * N + 1);

    if (in_valid && in_ready) begin
      s    = src.pop_front();
      s.re = model_conv(s.re);
      s.im = model_conv(s.im);
      frame.push_back(s);
      if (frame.size() == N) begin
        last_accept_cyc = cyc;
        for (int k = 0; k < N; k++) begin
          e.re  = frame[bitrev_int(k)].re;
          e.im  = frame[bitrev_int(k)].im;
          e.idx = k;
          exp_q.push_back(e);
        end
        frame.delete();
      end
    end

    if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      outs++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      got_re.push_back(out_re);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d got re=%h idx=%0d want none", cyc, out_re, out_idx);
      end else begin
        e = exp_q.pop_front();
        if (out_re !== e.re || out_im !== e.im || out_idx !== LOGN'(e.idx) || out_last !== (e.idx == N - 1)) begin
          failures++;
          $display("FAIL output cyc=%0d got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                   cyc, out_re, out_im, out_idx, out_last, e.re, e.im, e.idx, (e.idx == N - 1));
        end
      end
    end

    prev_hold = out_valid && !out_ready;
    h_re = out_re; h_im = out_im; h_idx = out_idx; h_last = out_last;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((src.size() > 0 || exp_q.size() > 0 || frame.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (src.size() > 0 || exp_q.size() > 0 || frame.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout left src=%0d exp=%0d part=%0d want 0 0 0", src.size(), exp_q.size(), frame.size());
    end
  endtask

  task automatic push_sample(input logic [W-1:0] re, input logic [W-1:0] im);
    samp_t s;
    s.re = re;
    s.im = im;
    src.push_back(s);
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    model_reset();
    valid_pct = 0;
    ready_pct = 100;
    rst = 1'b1;
    tick();
    tick();
    expect_int("in_ready_during_reset", int'(in_ready), 0);
    rst = 1'b0;
    tick();
    expect_int("in_ready_after_reset", int'(in_ready), 1);
    checks++;
    if ({out_valid, out_last, frame_drop, out_idx, out_re, out_im} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b last=%b drop=%b idx=%0d re=%h im=%h want all 0",
               out_valid, out_last, frame_drop, out_idx, out_re, out_im);
    end
  endtask

  task automatic test_ramp();
    valid_pct = 100;
    ready_pct = 100;
    got_re.delete();
    first_valid_cyc = -1;
    for (int i = 0; i < N; i++) push_sample(W'(i), W'(100 + i));
    run(200);
    expect_int("first_valid_latency", first_valid_cyc - last_accept_cyc, 3);
    expect_int("ramp_count", got_re.size(), N);
    if (got_re.size() == N) begin
      expect_int("ramp_k0", int'(got_re[0]), 0);
      expect_int("ramp_k1", int'(got_re[1]), 16);
      expect_int("ramp_k2", int'(got_re[2]), 8);
      expect_int("ramp_k3", int'(got_re[3]), 24);
      expect_int("ramp_k31", int'(got_re[31]), 31);
    end
  endtask

  task automatic test_back_to_back();
    valid_pct = 100;
    ready_pct = 100;
    stall_total = 0;
    outs = 0;
    first_out_cyc = -1;
    for (int i = 0; i < 3 * N; i++) push_sample(W'($urandom), W'($urandom));
    run(400);
    expect_int("continuous_stalls", stall_total, 0);
    expect_int("continuous_outs", outs, 3 * N);
    expect_int("continuous_span", last_out_cyc - first_out_cyc, 3 * N - 1);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] first_re;
    valid_pct = 100;
    ready_pct = 0;
    drop_seen = 0;
    for (int i = 0; i < 3 * N; i++) push_sample(W'($urandom), W'($urandom));
    first_re = model_conv(src[0].re);
    for (int i = 0; i < 140; i++) tick();
    expect_int("bp_accepted", 3 * N - src.size(), 2 * N);
    expect_int("bp_drop_pulses", drop_seen, 1);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== '0 || out_re !== first_re) begin
      failures++;
      $display("FAIL bp_held got v=%b idx=%0d re=%h want v=1 idx=0 re=%h", out_valid, out_idx, out_re, first_re);
    end
    ready_pct = 100;
    run(400);
  endtask

  task automatic test_random_flow();
    valid_pct = 60;
    ready_pct = 50;
    for (int i = 0; i < 5 * N; i++) push_sample(W'($urandom), W'($urandom));
    run(3000);
    valid_pct = 100;
    ready_pct = 100;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    valid_pct = 100;
    ready_pct = 100;
    for (int i = 0; i < 17; i++) push_sample(W'($urandom), W'($urandom));
    while (src.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    expect_int("mid_reset_out_valid", int'(out_valid), 0);
    got_re.delete();
    for (int i = 0; i < N; i++) push_sample(W'(200 + i), W'($urandom));
    run(200);
    expect_int("mid_reset_count", got_re.size(), N);
    if (got_re.size() == N) begin
      expect_int("mid_reset_k0", int'(got_re[0]), 200);
      expect_int("mid_reset_k1", int'(got_re[1]), 216);
      expect_int("mid_reset_k2", int'(got_re[2]), 208);
    end
  endtask

  task automatic test_signmag();
    logic [W-1:0] vin  [4];
    logic [W-1:0] vout [4];
    int           kpos [4];
    vin = '{16'hFFFB, 16'h0007, 16'h8000, 16'h0000};
`ifdef FFT_IN_SIGNMAG_CONV_EN
    vout = '{16'h8005, 16'h0007, 16'hFFFF, 16'h0000};
`else
    vout = '{16'hFFFB, 16'h0007, 16'h8000, 16'h0000};
`endif
    kpos = '{0, 16, 8, 24};
    valid_pct = 100;
    ready_pct = 100;
    got_re.delete();
    for (int i = 0; i < 4; i++) push_sample(vin[i], vin[3 - i]);
    for (int i = 4; i < N; i++) push_sample(W'($urandom), W'($urandom));
    run(200);
    expect_int("signmag_count", got_re.size(), N);
    if (got_re.size() == N)
      for (int i = 0; i < 4; i++) expect_int($sformatf("signmag_in%0d", i), int'(got_re[kpos[i]]), int'(vout[i]));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    test_reset();
    test_ramp();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_mid();
    test_signmag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
